// File: rtl/if_id_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_id_stage_pkg
// Shared constants and types for the IF/ID pipeline boundary:
//   OPC_HLT        opcode (instruction bits [15:12]) of the halt instruction
//   NOP_INSTR_DEF  default bubble instruction word
//   ifid_state_e   halt-tracking FSM states (ST_RUN / ST_HALTED)
// ----------------------------------------------------------------------------
package if_id_stage_pkg;

    localparam logic [3:0]  OPC_HLT       = 4'hF;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } ifid_state_e;

endpackage : if_id_stage_pkg

// File: rtl/if_id_stage_dff_en_clr_16bit.sv
// ----------------------------------------------------------------------------
// dff_en_clr_16bit
// 16-bit register with synchronous active-low reset, synchronous clear to a
// fixed value, and load enable. Priority: reset > clear > enable > hold.
// Ports:
//   clk_i   clock (rising edge)
//   rst_ni  synchronous active-low reset, loads RST_VAL
//   clr_i   synchronous clear, loads CLR_VAL
//   en_i    load enable, captures d_i
//   d_i     data in
//   q_o     registered data out
// ----------------------------------------------------------------------------
module dff_en_clr_16bit #(
    parameter logic [15:0] RST_VAL = 16'h0000,
    parameter logic [15:0] CLR_VAL = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [15:0] d_i,
    output logic [15:0] q_o
);

    logic [15:0] data_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= RST_VAL;
        end else if (clr_i) begin
            data_q <= CLR_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : dff_en_clr_16bit

// File: rtl/if_id_stage.sv
// ----------------------------------------------------------------------------
// if_id_stage
// IF/ID pipeline boundary. Captures the fetched instruction and PC+2 each
// cycle, holds on stall, squashes to a bubble on flush, and freezes while a
// valid halt instruction sits in ID.
//
// Ports:
//   clk              pipeline clock, rising edge
//   rst              synchronous active-low reset
//   stall            hold current contents
//   flush            squash slot to bubble (overrides stall and halt)
//   pc_curr2_in      PC+2 from fetch
//   instruction_in   instruction word from fetch
//   pc_curr2_out     registered PC+2
//   instruction_out  registered instruction, NOP_INSTR when bubble
//   opcode_out       instruction_out[15:12]
//   valid_out        slot holds a real instruction
//   halted           a valid HLT sits in ID, stage frozen
//
// Optional build macro IFID_PERF_CNT_EN adds:
//   stall_cnt        saturating count of stall edges (stall without flush)
//   flush_cnt        saturating count of flush edges
// ----------------------------------------------------------------------------
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [3:0]  HLT_OPC   = OPC_HLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] pc_curr2_in,
    input  logic [15:0] instruction_in,
    output logic [15:0] pc_curr2_out,
    output logic [15:0] instruction_out,
    output logic [3:0]  opcode_out,
    output logic        valid_out,
    output logic        halted
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    ifid_state_e state_q, state_d;
    logic        valid_q, valid_d;
    logic        load_en;
    logic [15:0] pc_q;
    logic [15:0] instr_q;

    // A load happens only when nothing of higher priority claims the edge;
    // while halted, fetch data is ignored until a flush or reset.
    assign load_en = !flush && (state_q == ST_RUN) && !stall;

    dff_en_clr_16bit #(
        .RST_VAL (16'h0000),
        .CLR_VAL (16'h0000)
    ) u_pc_reg (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (flush),
        .en_i   (load_en),
        .d_i    (pc_curr2_in),
        .q_o    (pc_q)
    );

    dff_en_clr_16bit #(
        .RST_VAL (NOP_INSTR),
        .CLR_VAL (NOP_INSTR)
    ) u_instr_reg (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (flush),
        .en_i   (load_en),
        .d_i    (instruction_in),
        .q_o    (instr_q)
    );

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load_en) begin
            valid_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                // Only a word actually captured by a load can halt; bubbles
                // and words arriving under stall never do.
                if (load_en && (instruction_in[15:12] == HLT_OPC)) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (flush) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    assign pc_curr2_out    = pc_q;
    assign instruction_out = instr_q;
    assign opcode_out      = instr_q[15:12];
    assign valid_out       = valid_q;
    assign halted          = (state_q == ST_HALTED);

`ifdef IFID_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            if (flush_cnt_q != 16'hFFFF) begin
                flush_cnt_d = flush_cnt_q + 16'd1;
            end
        end else if (stall) begin
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule : if_id_stage

// File: tb/tb_if_id_stage.sv
// ----------------------------------------------------------------------------
// tb_if_id_stage
// Directed vectors for if_id_stage. Each applied vector pushes its
// hand-computed expected outputs into a queue; a monitor pops one entry after
// every rising edge and compares it with what the DUT presents.
// ----------------------------------------------------------------------------
module tb_if_id_stage;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic        valid;
        logic        halted;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [15:0] pc_curr2_in;
    logic [15:0] instruction_in;
    logic [15:0] pc_curr2_out;
    logic [15:0] instruction_out;
    logic [3:0]  opcode_out;
    logic        valid_out;
    logic        halted;
`ifdef IFID_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   done   = 1'b0;

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .pc_curr2_in     (pc_curr2_in),
        .instruction_in  (instruction_in),
        .pc_curr2_out    (pc_curr2_out),
        .instruction_out (instruction_out),
        .opcode_out      (opcode_out),
        .valid_out       (valid_out),
        .halted          (halted)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    // Drive one vector (effective at the next rising edge) and queue the
    // outputs expected right after that edge.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic [15:0] pc, input logic [15:0] ins,
                        input logic [15:0] e_pc, input logic [15:0] e_ins,
                        input logic e_v, input logic e_h, input string nm);
        exp_t e;
        @(negedge clk);
        rst            = r;
        stall          = s;
        flush          = f;
        pc_curr2_in    = pc;
        instruction_in = ins;
        e.pc     = e_pc;
        e.instr  = e_ins;
        e.valid  = e_v;
        e.halted = e_h;
        e.name   = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: sample 2 time units after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        logic [15:0] e_ins;
        bit bad;
        #2;
        if (exp_q.size() > 0) begin
            e     = exp_q.pop_front();
            e_ins = e.instr;
            bad   = 1'b0;
            n_vec++;
            if (pc_curr2_out !== e.pc) begin
                $display("FAIL %s pc_curr2_out got %h want %h", e.name, pc_curr2_out, e.pc);
                bad = 1'b1;
            end
            if (instruction_out !== e_ins) begin
                $display("FAIL %s instruction_out got %h want %h", e.name, instruction_out, e_ins);
                bad = 1'b1;
            end
            if (opcode_out !== e_ins[15:12]) begin
                $display("FAIL %s opcode_out got %h want %h", e.name, opcode_out, e_ins[15:12]);
                bad = 1'b1;
            end
            if (valid_out !== e.valid) begin
                $display("FAIL %s valid_out got %b want %b", e.name, valid_out, e.valid);
                bad = 1'b1;
            end
            if (halted !== e.halted) begin
                $display("FAIL %s halted got %b want %b", e.name, halted, e.halted);
                bad = 1'b1;
            end
            if (bad) n_err++;
        end
    end

    initial begin
        int budget;
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        pc_curr2_in = 16'h0000; instruction_in = 16'h0000;

        // reset, then first load
        step(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, "reset1");
        step(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, "reset2");
        step(1, 0, 0, 16'h0002, 16'h1234, 16'h0002, 16'h1234, 1, 0, "load1234");

        // stall hold for 3 cycles, new word appears after stall drops
        step(1, 0, 0, 16'h0004, 16'h2345, 16'h0004, 16'h2345, 1, 0, "load2345");
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 16'h0006, 16'h5555, 16'h0004, 16'h2345, 1, 0, "stall_hold");
        step(1, 0, 0, 16'h0006, 16'h5555, 16'h0006, 16'h5555, 1, 0, "load5555");

        // flush beats stall; flush alone
        step(1, 1, 1, 16'h0008, 16'h6666, 16'h0000, 16'h0000, 0, 0, "flush_stall");
        step(1, 0, 1, 16'h0008, 16'h6666, 16'h0000, 16'h0000, 0, 0, "flush_only");

        // halt capture and freeze regardless of stall
        step(1, 0, 0, 16'h0008, 16'hF000, 16'h0008, 16'hF000, 1, 1, "halt_capture");
        for (int i = 0; i < 4; i++)
            step(1, i[0], 0, 16'h000A, 16'h1111, 16'h0008, 16'hF000, 1, 1, "halt_hold");

        // flush releases halt, next load is normal
        step(1, 0, 1, 16'h000A, 16'h1111, 16'h0000, 16'h0000, 0, 0, "halt_squash");
        step(1, 0, 0, 16'h000C, 16'h3000, 16'h000C, 16'h3000, 1, 0, "load3000");

        // HLT under stall is not captured
        step(1, 1, 0, 16'h000E, 16'hF0AA, 16'h000C, 16'h3000, 1, 0, "hlt_stalled");
        step(1, 0, 0, 16'h000E, 16'h4321, 16'h000E, 16'h4321, 1, 0, "load4321");

        // reset while halted and stalled
        step(1, 0, 0, 16'h0010, 16'hF123, 16'h0010, 16'hF123, 1, 1, "halt2");
        step(0, 1, 0, 16'h0012, 16'h7777, 16'h0000, 16'h0000, 0, 0, "reset_halted");
        step(1, 0, 0, 16'h0014, 16'hABCD, 16'h0014, 16'hABCD, 1, 0, "loadABCD");

`ifdef IFID_PERF_CNT_EN
        // counters: 5 stalls, 2 flushes, 1 stall+flush
        step(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, "perf_reset");
        for (int i = 0; i < 5; i++)
            step(1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, "perf_stall");
        for (int i = 0; i < 2; i++)
            step(1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, "perf_flush");
        step(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, "perf_both");
        step(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, "perf_idle");
        @(negedge clk);
        n_vec++;
        if (stall_cnt !== 16'd5 || flush_cnt !== 16'd3) begin
            $display("FAIL perf_counts stall_cnt got %0d want 5, flush_cnt got %0d want 3",
                     stall_cnt, flush_cnt);
            n_err++;
        end
        // drive the stall counter past saturation
        for (int i = 0; i < 65540; i++)
            step(1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, "perf_sat");
        step(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, "perf_idle2");
        @(negedge clk);
        n_vec++;
        if (stall_cnt !== 16'hFFFF || flush_cnt !== 16'd3) begin
            $display("FAIL perf_saturate stall_cnt got %h want ffff, flush_cnt got %0d want 3",
                     stall_cnt, flush_cnt);
            n_err++;
        end
`endif

        // let the monitor drain the queue, bounded
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            $display("FAIL drain %0d expectations left unchecked, want 0", exp_q.size());
            n_err++;
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_if_id_stage
